// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexed Izhikevich neuron scheduler: holds per-neuron v/u/I and the global
// a/b/c/d/p, sweeps every neuron through one shared datapath per step, applies the spike reset.
module izh_neuron_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             step_tick,
    output logic             busy,
    output logic             step_overrun,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_sel,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [17:0]      cfg_data,
    output logic             cfg_err,
    output logic             dp_req,
    output logic [17:0]      dp_v,
    output logic [17:0]      dp_u,
    output logic [17:0]      dp_I,
    output logic [17:0]      dp_a,
    output logic [17:0]      dp_b,
    input  logic             dp_ack,
    input  logic [17:0]      dp_vnew,
    input  logic [17:0]      dp_unew,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx
);

    localparam logic [17:0] LP_V0 = 18'h3599A;
    localparam logic [17:0] LP_U0 = 18'h03333;
    localparam logic [17:0] LP_I0 = 18'h02666;
    localparam logic [17:0] LP_A0 = 18'h0051F;
    localparam logic [17:0] LP_B0 = 18'h03333;
    localparam logic [17:0] LP_C0 = 18'h38000;
    localparam logic [17:0] LP_D0 = 18'h0051F;
    localparam logic [17:0] LP_P0 = 18'h04CCD;

    // One extra bit so N_NEURONS itself is representable for the range check.
    localparam logic [IDX_W:0]   LP_N    = (IDX_W+1)'(N_NEURONS);
    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic signed [17:0] r_v [N_NEURONS];
    logic signed [17:0] r_u [N_NEURONS];
    logic signed [17:0] r_I [N_NEURONS];
    logic signed [17:0] r_a, r_b, r_c, r_d, r_p;
    logic signed [17:0] r_vnew, r_unew;

    logic               w_busy;
    logic               w_in_req;
    logic               w_idx_ok;
    logic               w_cfg_ok;
    logic               w_last;
    logic               w_spike;
    logic signed [17:0] w_cur_v, w_cur_u, w_cur_I;
    logic signed [18:0] w_usum;
    logic signed [17:0] w_usat;

    assign w_busy   = (r_state != S_IDLE);
    assign w_in_req = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_idx_ok = ({1'b0, cfg_idx} < LP_N);
    assign w_cfg_ok = cfg_we && !w_busy && w_idx_ok;
    assign w_last   = (r_idx == LP_LAST);

    assign w_cur_v = r_v[r_idx];
    assign w_cur_u = r_u[r_idx];
    assign w_cur_I = r_I[r_idx];

    // Spike decision looks at the pre-update v held in the state array.
    assign w_spike = (r_state == S_WRITE) && (w_cur_v > r_p);

    assign w_usum = {w_cur_u[17], w_cur_u} + {r_d[17], r_d};
    always_comb begin
        w_usat = w_usum[17:0];
        if (w_usum[18] != w_usum[17])
            w_usat = w_usum[18] ? 18'sh20000 : 18'sh1FFFF;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (step_tick) w_next = S_ISSUE;
            S_ISSUE: w_next = dp_ack ? S_WRITE : S_WAIT;
            S_WAIT:  if (dp_ack) w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_IDLE : S_ISSUE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy         = !reset && w_busy;
    assign step_overrun = !reset && step_tick && w_busy;
    assign cfg_err      = !reset && cfg_we && (w_busy || !w_idx_ok);
    assign dp_req       = !reset && w_in_req;
    assign dp_v         = dp_req ? w_cur_v : 18'h0;
    assign dp_u         = dp_req ? w_cur_u : 18'h0;
    assign dp_I         = dp_req ? w_cur_I : 18'h0;
    assign dp_a         = dp_req ? r_a : 18'h0;
    assign dp_b         = dp_req ? r_b : 18'h0;
    assign spike_valid  = !reset && w_spike;
    assign spike_idx    = spike_valid ? r_idx : '0;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_vnew  <= '0;
            r_unew  <= '0;
            r_a     <= LP_A0;
            r_b     <= LP_B0;
            r_c     <= LP_C0;
            r_d     <= LP_D0;
            r_p     <= LP_P0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i] <= LP_V0;
                r_u[i] <= LP_U0;
                r_I[i] <= LP_I0;
            end
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && step_tick)
                r_idx <= '0;
            else if (r_state == S_WRITE && !w_last)
                r_idx <= r_idx + 1'b1;

            if (w_in_req && dp_ack) begin
                r_vnew <= dp_vnew;
                r_unew <= dp_unew;
            end

            if (r_state == S_WRITE) begin
                if (w_spike) begin
                    r_v[r_idx] <= r_c;
                    r_u[r_idx] <= w_usat;
                end else begin
                    r_v[r_idx] <= r_vnew;
                    r_u[r_idx] <= r_unew;
                end
            end

            // Config writes are only accepted in IDLE, so they never collide with WRITE.
            if (w_cfg_ok) begin
                case (cfg_sel)
                    3'd0: r_a <= cfg_data;
                    3'd1: r_b <= cfg_data;
                    3'd2: r_c <= cfg_data;
                    3'd3: r_d <= cfg_data;
                    3'd4: r_p <= cfg_data;
                    3'd5: r_I[cfg_idx] <= cfg_data;
                    3'd6: r_v[cfg_idx] <= cfg_data;
                    default: r_u[cfg_idx] <= cfg_data;
                endcase
            end
        end
    end

endmodule
